// File: rtl/emsg_expand_pkg.sv
// Shared definitions for the check-node message compressor/expander pair.
// Holds the default geometry (W, WC, P, NB, POS_W), the bit offsets of the
// fields inside a compressed message, and the expander FSM state type.
// Compressed message layout, MSB to LSB:
//   {min1[W-2:0], min2[W-2:0], pos[POS_W-1:0], sign[WC-1:0]}
package emsg_expand_pkg;

    localparam int W     = 6;       // bits per expanded message (sign + magnitude)
    localparam int WC    = 18;      // check-node degree
    localparam int P     = 6;       // messages per output beat
    localparam int NB    = WC / P;  // beats per compressed message
    localparam int POS_W = 5;       // width of the min1 position field

    // Field offsets for the default geometry.
    localparam int SIGN_LSB = 0;
    localparam int POS_LSB  = SIGN_LSB + WC;
    localparam int MIN2_LSB = POS_LSB + POS_W;
    localparam int MIN1_LSB = MIN2_LSB + (W - 1);
    localparam int ECOMP_W  = MIN1_LSB + (W - 1);

    // Offsets for an arbitrary geometry, so parameterised instances stay
    // consistent with the layout above.
    function automatic int pos_lsb(input int wc);
        return wc;
    endfunction

    function automatic int min2_lsb(input int wc);
        return wc + POS_W;
    endfunction

    function automatic int min1_lsb(input int w, input int wc);
        return wc + POS_W + (w - 1);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/emsg_lane.sv
// One expanded-message lane: turns the compressed fields into the W-bit
// sign-magnitude message for a single edge.
// Ports:
//   edge_idx_i  edge index served by this lane in the current beat
//   min1_i      smallest magnitude of the check node
//   min2_i      second smallest magnitude (sent back to the min1 edge)
//   pos_i       edge index that held min1 (>= WC means "no such edge")
//   sign_i      final sign of this edge
//   msg_o       {sign, magnitude}, sign forced 0 for a zero magnitude
module emsg_lane #(
    parameter int W   = 6,
    parameter int WC  = 18,
    parameter int OFS = 0,
    parameter int EW  = 5
) (
    input  logic [EW-1:0]                   edge_idx_i,
    input  logic [W-2:0]                    min1_i,
    input  logic [W-2:0]                    min2_i,
    input  logic [emsg_expand_pkg::POS_W-1:0] pos_i,
    input  logic                            sign_i,
    output logic [W-1:0]                    msg_o
);

    localparam int MAG_W = W - 1;

    logic             pos_hit;
    logic [MAG_W-1:0] raw_mag;
    logic [MAG_W-1:0] mag;

    // An out-of-range position never matches, so every edge gets min1.
    assign pos_hit = (int'(pos_i) < WC) && (EW'(pos_i) == edge_idx_i);
    assign raw_mag = pos_hit ? min2_i : min1_i;

    // Offset min-sum: subtract OFS, clamp at zero instead of wrapping.
    assign mag = (int'(raw_mag) > OFS) ? (raw_mag - MAG_W'(OFS)) : '0;

    // A zero magnitude carries no sign, keeping a unique encoding of zero.
    assign msg_o = {sign_i && (mag != '0), mag};

endmodule

// File: rtl/emsg_expand.sv
// Check-node message expander. Accepts one compressed message and streams
// its WC expanded messages out as NB beats of P lanes each, with
// valid/ready handshakes on both sides. A new compressed message may be
// accepted in the same cycle the last beat of the previous one transfers,
// giving one message per NB cycles back-to-back.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   ecomp      compressed message {min1, min2, pos, sign}
//   in_valid   ecomp valid
//   in_ready   block can accept ecomp this cycle
//   out_msg    P lanes of W bits; lane j is edge out_beat*P+j
//   out_valid  out_msg valid
//   out_ready  downstream accepts out_msg this cycle
//   out_beat   index of the current beat
//   out_last   high on the final beat of a message
module emsg_expand #(
    parameter int W   = emsg_expand_pkg::W,
    parameter int WC  = emsg_expand_pkg::WC,
    parameter int P   = emsg_expand_pkg::P,   // WC must be a multiple of P
    parameter int OFS = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [2*(W-1)+emsg_expand_pkg::POS_W+WC-1:0]   ecomp,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    output logic [P*W-1:0]                                 out_msg,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [((WC/P) > 1 ? $clog2(WC/P) : 1)-1:0]     out_beat,
    output logic                                           out_last
);

    import emsg_expand_pkg::*;

    localparam int N_BEATS = WC / P;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int MAG_W   = W - 1;
    localparam int EW      = ($clog2(WC) > POS_W) ? $clog2(WC) : POS_W;
    localparam int F_POS   = pos_lsb(WC);
    localparam int F_MIN2  = min2_lsb(WC);
    localparam int F_MIN1  = min1_lsb(W, WC);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q,  beat_d;
    logic [MAG_W-1:0]   min1_q,  min1_d;
    logic [MAG_W-1:0]   min2_q,  min2_d;
    logic [POS_W-1:0]   pos_q,   pos_d;
    logic [WC-1:0]      sign_q,  sign_d;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q == ST_EMIT);
    assign out_last  = out_valid && (beat_q == BEAT_W'(N_BEATS - 1));
    assign out_beat  = beat_q;
    // Accepting on the last beat only depends on out_ready, never on in_valid,
    // so there is no combinational loop through an upstream handshake.
    assign in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        pos_d   = pos_q;
        sign_d  = sign_q;

        if (in_xfer) begin
            min1_d = ecomp[F_MIN1 +: MAG_W];
            min2_d = ecomp[F_MIN2 +: MAG_W];
            pos_d  = ecomp[F_POS  +: POS_W];
            sign_d = ecomp[WC-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    state_d = ST_EMIT;
                    beat_d  = '0;
                end
            end
            ST_EMIT: begin
                if (out_xfer) begin
                    if (out_last) begin
                        // in_xfer here means the next message starts at once.
                        beat_d  = '0;
                        state_d = in_xfer ? ST_EMIT : ST_IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            pos_q   <= '0;
            sign_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            pos_q   <= pos_d;
            sign_q  <= sign_d;
        end
    end

    // Lanes read the registered fields directly; out_msg is zero when idle.
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        logic [EW-1:0] edge_idx;
        logic [W-1:0]  lane_msg;

        assign edge_idx = EW'(int'(beat_q) * P + gi);

        emsg_lane #(
            .W   (W),
            .WC  (WC),
            .OFS (OFS),
            .EW  (EW)
        ) u_lane (
            .edge_idx_i (edge_idx),
            .min1_i     (min1_q),
            .min2_i     (min2_q),
            .pos_i      (pos_q),
            .sign_i     (sign_q[edge_idx]),
            .msg_o      (lane_msg)
        );

        assign out_msg[gi*W +: W] = out_valid ? lane_msg : '0;
    end

endmodule

// File: tb/tb_emsg_expand.sv
module tb_emsg_expand;

    localparam int W   = 6;
    localparam int WC  = 18;
    localparam int P   = 6;
    localparam int NB  = 3;
    localparam int MW  = W - 1;
    localparam int ECW = 2 * MW + 5 + WC;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ECW-1:0]  ecomp = '0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;

    logic            in_ready0, out_valid0, out_last0;
    logic [P*W-1:0]  out_msg0;
    logic [1:0]      out_beat0;
    logic            in_ready4, out_valid4, out_last4;
    logic [P*W-1:0]  out_msg4;
    logic [1:0]      out_beat4;

    always #5 clk = ~clk;

    emsg_expand #(.W(W), .WC(WC), .P(P), .OFS(0)) u_dut0 (
        .clk(clk), .rst(rst), .ecomp(ecomp), .in_valid(in_valid),
        .in_ready(in_ready0), .out_msg(out_msg0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_beat(out_beat0), .out_last(out_last0)
    );

    emsg_expand #(.W(W), .WC(WC), .P(P), .OFS(4)) u_dut4 (
        .clk(clk), .rst(rst), .ecomp(ecomp), .in_valid(in_valid),
        .in_ready(in_ready4), .out_msg(out_msg4), .out_valid(out_valid4),
        .out_ready(out_ready), .out_beat(out_beat4), .out_last(out_last4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] ref_edge(input int m1, input int m2, input int pos,
                                              input bit sgn, input int e, input int ofs);
        int raw;
        int mag;
        raw = (pos < WC && pos == e) ? m2 : m1;
        mag = raw - ofs;
        if (mag < 0) mag = 0;
        return {sgn && (mag != 0), mag[MW-1:0]};
    endfunction

    function automatic logic [P*W-1:0] ref_beat(input int m1, input int m2, input int pos,
                                                input logic [WC-1:0] sg, input int beat, input int ofs);
        logic [P*W-1:0] r;
        r = '0;
        for (int j = 0; j < P; j++)
            r[j*W +: W] = ref_edge(m1, m2, pos, sg[beat*P+j], beat*P + j, ofs);
        return r;
    endfunction

    function automatic logic [ECW-1:0] pack(input int m1, input int m2, input int pos,
                                            input logic [WC-1:0] sg);
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [4:0]    p;
        a = m1[MW-1:0];
        b = m2[MW-1:0];
        p = pos[4:0];
        return {a, b, p, sg};
    endfunction

    function automatic logic [W-1:0] lane_of(input logic [P*W-1:0] m, input int j);
        return m[j*W +: W];
    endfunction

    // Model state: the message currently being emitted and its beat.
    bit            m_busy = 1'b0;
    int            m_beat = 0;
    int            m_m1, m_m2, m_pos;
    logic [WC-1:0] m_sign;

    always @(negedge clk) begin
        bit exp_ir;
        if (!rst) begin
            chk("rst_valid", out_valid0, 0);
            chk("rst_valid4", out_valid4, 0);
            chk("rst_msg", out_msg0, 0);
            chk("rst_msg4", out_msg4, 0);
            chk("rst_beat", out_beat0, 0);
            chk("rst_last", out_last0, 0);
            m_busy = 1'b0;
            m_beat = 0;
        end else begin
            exp_ir = !m_busy || (m_beat == NB - 1 && out_ready);
            chk("in_ready", in_ready0, exp_ir);
            chk("in_ready4", in_ready4, exp_ir);
            chk("out_valid", out_valid0, m_busy);
            chk("out_valid4", out_valid4, m_busy);
            if (m_busy) begin
                chk("out_beat", out_beat0, m_beat);
                chk("out_last", out_last0, m_beat == NB - 1);
                chk("out_msg", out_msg0, ref_beat(m_m1, m_m2, m_pos, m_sign, m_beat, 0));
                chk("out_msg4", out_msg4, ref_beat(m_m1, m_m2, m_pos, m_sign, m_beat, 4));
            end else begin
                chk("idle_last", out_last0, 0);
            end
            // Advance the model to what the coming rising edge will do.
            if (m_busy && out_ready) begin
                if (m_beat == NB - 1) begin
                    m_busy = 1'b0;
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (in_valid && exp_ir) begin
                m_m1   = int'(ecomp[ECW-1 -: MW]);
                m_m2   = int'(ecomp[ECW-1-MW -: MW]);
                m_pos  = int'(ecomp[WC+4 -: 5]);
                m_sign = ecomp[WC-1:0];
                m_busy = 1'b1;
                m_beat = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Presents one message and returns just after the edge that accepted it.
    task automatic send(input int m1, input int m2, input int pos, input logic [WC-1:0] sg);
        int k;
        @(posedge clk); #1;
        ecomp    = pack(m1, m2, pos, sg);
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("send_timeout", k >= 50, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NB + 2) @(posedge clk);
        #1;
    endtask

    logic [WC-1:0] rs;

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready0, 1);

        // Basic expansion with min2 routed to the min1 edge.
        out_ready = 1'b1;
        send(3, 7, 4, 18'h00001);
        @(negedge clk);
        chk("b0_lane0", lane_of(out_msg0, 0), 6'h23);
        chk("b0_lane4", lane_of(out_msg0, 4), 6'h07);
        chk("b0_lane1", lane_of(out_msg0, 1), 6'h03);
        chk("b0_lane5", lane_of(out_msg0, 5), 6'h03);
        chk("b0_last", out_last0, 0);
        @(negedge clk);
        for (int j = 0; j < P; j++) chk("b1_lane", lane_of(out_msg0, j), 6'h03);
        chk("b1_last", out_last0, 0);
        @(negedge clk);
        for (int j = 0; j < P; j++) chk("b2_lane", lane_of(out_msg0, j), 6'h03);
        chk("b2_last", out_last0, 1);
        drain();

        // Offset saturation and sign forcing (OFS=4 instance).
        send(3, 9, 17, '1);
        @(negedge clk);
        chk("ofs_b0", out_msg4, 0);
        @(negedge clk);
        chk("ofs_b1", out_msg4, 0);
        @(negedge clk);
        for (int j = 0; j < P - 1; j++) chk("ofs_b2_lane", lane_of(out_msg4, j), 6'h00);
        chk("ofs_edge17", lane_of(out_msg4, 5), 6'h25);
        chk("ofs0_edge17", lane_of(out_msg0, 5), 6'h29);
        chk("ofs0_edge12", lane_of(out_msg0, 0), 6'h23);
        drain();

        // Out-of-range position selects min1 everywhere.
        send(2, 30, 20, '0);
        for (int b = 0; b < NB; b++) begin
            @(negedge clk);
            for (int j = 0; j < P; j++) chk("pos20_lane", lane_of(out_msg0, j), 6'h02);
        end
        drain();

        // Back-to-back messages with in_valid held high.
        @(posedge clk); #1;
        ecomp    = pack(5, 12, 1, 18'h2A5C3);
        in_valid = 1'b1;
        @(posedge clk); #1;
        ecomp    = pack(9, 1, 16, 18'h15A3C);
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            chk("b2b_valid", out_valid0, 1);
            chk("b2b_in_ready", in_ready0, (i % NB) == NB - 1);
            chk("b2b_beat", out_beat0, i % NB);
            if (i == NB - 1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", out_valid0, 0);
        drain();

        // Backpressure during beat 1.
        send(5, 11, 8, 18'h3C0F1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_beat", out_beat0, 1);
            chk("stall_msg", out_msg0, ref_beat(5, 11, 8, 18'h3C0F1, 1, 0));
            chk("stall_in_ready", in_ready0, 0);
            chk("stall_valid", out_valid0, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_beat", out_beat0, 1);
        chk("resume_msg", out_msg0, ref_beat(5, 11, 8, 18'h3C0F1, 1, 0));
        @(negedge clk);
        chk("resume_beat2", out_beat0, 2);
        drain();

        // Asynchronous reset in the middle of a message.
        send(7, 3, 10, 18'h0FFFF);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid0, 0);
        chk("arst_msg", out_msg0, 0);
        chk("arst_beat", out_beat0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", in_ready0, 1);
        chk("arst_no_beats", out_valid0, 0);
        send(4, 6, 0, 18'h00003);
        @(negedge clk);
        chk("arst_next_beat", out_beat0, 0);
        chk("arst_next_msg", out_msg0, ref_beat(4, 6, 0, 18'h00003, 0, 0));
        drain();

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rs        = WC'($urandom);
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 4) != 0;
            ecomp     = pack(int'($urandom % 32), int'($urandom % 32),
                             int'($urandom_range(0, 31)), rs);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
